cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/tomasulo_pkg.sv | 21 ++
 rtl/rr_pick.sv | 29 ++
 rtl/cdb_arbiter.sv | 113 +++++++++++
 tb/tb_cdb_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default CDB widths, the CDB bus record and a
// saturating counter helper used by the CDB arbiter.
package tomasulo_pkg;

  localparam int TagW  = 3;
  localparam int DataW = 32;
  localparam int CntW  = 16;

  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  typedef struct packed {
    logic             valid;
    logic [TagW-1:0]  tag;
    logic [DataW-1:0] data;
  } cdb_bus_t;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority one-hot picker: the first asserted req at or after ptr,
// scanning upward modulo N, wins.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int PtrW = $clog2(N);

  logic            found;
  logic [PtrW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PtrW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units, with a
// registered one-cycle broadcast stage and a saturating broadcast counter.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = TagW,
  parameter int DATA_W = DataW
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic                      stall,
  input  logic                      flush,
  output logic [N_REQ-1:0]          gnt,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [$clog2(N_REQ)-1:0]  cdb_src,
  output logic [CntW-1:0]           bcast_cnt
);

  localparam int SrcW = $clog2(N_REQ);

  logic              arb_en;
  logic [N_REQ-1:0]  req_eligible;
  logic              grant;
  logic [SrcW-1:0]   win_idx;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SrcW-1:0]   src_q, src_d;
  logic [SrcW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   bcast_cnt_q, bcast_cnt_d;

  // Masking requests here makes flush/stall/reset suppress the grant, which
  // in turn leaves the pointer and counter untouched on those cycles.
  assign arb_en       = RSTn & ~stall & ~flush;
  assign req_eligible = arb_en ? req : '0;

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req (req_eligible),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  always_comb begin
    grant    = |gnt;
    win_idx  = '0;
    win_tag  = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_idx  = SrcW'(i);
        win_tag  = req_tag[i*TAG_W +: TAG_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    valid_d     = grant;
    tag_d       = tag_q;
    data_d      = data_q;
    src_d       = src_q;
    rr_ptr_d    = rr_ptr_q;
    bcast_cnt_d = bcast_cnt_q;
    if (grant) begin
      tag_d       = win_tag;
      data_d      = win_data;
      src_d       = win_idx;
      rr_ptr_d    = (win_idx == SrcW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      bcast_cnt_d = sat_inc(bcast_cnt_q);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid_q     <= 1'b0;
      tag_q       <= '0;
      data_q      <= '0;
      src_q       <= '0;
      rr_ptr_q    <= '0;
      bcast_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      src_q       <= src_d;
      rr_ptr_q    <= rr_ptr_d;
      bcast_cnt_q <= bcast_cnt_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;
  assign cdb_src   = src_q;
  assign bcast_cnt = bcast_cnt_q;

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge CLK) disable iff (!RSTn) $onehot0(gnt));
  a_gnt_blocked : assert property (@(posedge CLK) (stall || flush || !RSTn) |-> (gnt == '0));
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table plus hand-written
// saturation and mid-broadcast reset sequences, with a broadcast scoreboard.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 3;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            CLK = 1'b0;
  logic            RSTn;
  logic [N-1:0]    req;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic            stall;
  logic            flush;
  logic [N-1:0]    gnt;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [SW-1:0]   cdb_src;
  logic [15:0]     bcast_cnt;

  cdb_arbiter #(
    .N_REQ  (N),
    .TAG_W  (TW),
    .DATA_W (DW)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .req       (req),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .stall     (stall),
    .flush     (flush),
    .gnt       (gnt),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .bcast_cnt (bcast_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0] req;
    logic         stall;
    logic         flush;
    logic [N-1:0] gnt;
  } vec_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [SW-1:0] src;
  } exp_t;

  exp_t          sbq[$];
  vec_t          vecs[$];
  int            n_cmp;
  int            n_bad;
  logic [15:0]   exp_cnt;
  logic [TW-1:0] last_tag;
  logic [DW-1:0] last_data;
  logic [SW-1:0] last_src;
  logic [TW-1:0] u_tag [N];
  logic [DW-1:0] u_data[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = u_tag[i];
      req_data[i*DW +: DW] = u_data[i];
    end
  endtask

  task automatic clear_model();
    sbq.delete();
    exp_cnt   = '0;
    last_tag  = '0;
    last_data = '0;
    last_src  = '0;
  endtask

  // One arbitration cycle: check the combinational grant, score the expected
  // broadcast, then check the registered bus and counter after the edge.
  task automatic cycle(input logic [N-1:0] r, input logic s, input logic f,
                       input logic [N-1:0] eg);
    exp_t e;
    int   w;
    req   = r;
    stall = s;
    flush = f;
    #1;
    check("gnt", gnt, eg);
    if (eg != '0) begin
      w = 0;
      for (int i = 0; i < N; i++) if (eg[i]) w = i;
      e.tag  = u_tag[w];
      e.data = u_data[w];
      e.src  = SW'(w);
      sbq.push_back(e);
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
    end
    @(posedge CLK);
    #1;
    check("cdb_valid", cdb_valid, eg != '0);
    if (cdb_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: got unexpected broadcast tag %0h, expected none", cdb_tag);
      end else begin
        e = sbq.pop_front();
        check("cdb_tag", cdb_tag, e.tag);
        check("cdb_data", cdb_data, e.data);
        check("cdb_src", cdb_src, e.src);
        last_tag  = e.tag;
        last_data = e.data;
        last_src  = e.src;
      end
    end else begin
      check("hold_tag", cdb_tag, last_tag);
      check("hold_data", cdb_data, last_data);
      check("hold_src", cdb_src, last_src);
    end
    check("bcast_cnt", bcast_cnt, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    u_tag  = '{3'd1, 3'd2, 3'd5, 3'd4};
    u_data = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003};
    drive_bus();
    clear_model();

    // Round-robin with all units requesting, then stall, latency, wrap, flush.
    repeat (2) begin
      vecs.push_back('{4'b1111, 1'b0, 1'b0, 4'b0001});
      vecs.push_back('{4'b1111, 1'b0, 1'b0, 4'b0010});
      vecs.push_back('{4'b1111, 1'b0, 1'b0, 4'b0100});
      vecs.push_back('{4'b1111, 1'b0, 1'b0, 4'b1000});
    end
    repeat (3) vecs.push_back('{4'b1010, 1'b1, 1'b0, 4'b0000});
    vecs.push_back('{4'b1010, 1'b0, 1'b0, 4'b0010});
    vecs.push_back('{4'b1000, 1'b0, 1'b0, 4'b1000});
    vecs.push_back('{4'b0100, 1'b0, 1'b0, 4'b0100});
    vecs.push_back('{4'b0000, 1'b0, 1'b0, 4'b0000});
    vecs.push_back('{4'b1001, 1'b0, 1'b0, 4'b1000});
    vecs.push_back('{4'b1001, 1'b0, 1'b0, 4'b0001});
    vecs.push_back('{4'b0010, 1'b0, 1'b0, 4'b0010});
    vecs.push_back('{4'b1111, 1'b0, 1'b1, 4'b0000});
    vecs.push_back('{4'b1111, 1'b1, 1'b1, 4'b0000});
    vecs.push_back('{4'b1111, 1'b0, 1'b0, 4'b0100});
    vecs.push_back('{4'b0000, 1'b0, 1'b0, 4'b0000});

    req   = 4'b1111;
    stall = 1'b0;
    flush = 1'b0;
    RSTn  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_valid", cdb_valid, 1'b0);
    check("rst_cnt", bcast_cnt, 16'h0);
    check("rst_tag", cdb_tag, 3'd0);
    check("rst_data", cdb_data, 32'h0);
    check("rst_src", cdb_src, 2'd0);
    #2 RSTn = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      cycle(vecs[v].req, vecs[v].stall, vecs[v].flush, vecs[v].gnt);
    end
    check("cnt_after_table", bcast_cnt, 16'd15);

    // Saturation: preload near the top on an idle edge, then two grants.
    force dut.bcast_cnt_q = 16'hFFFE;
    exp_cnt = 16'hFFFE;
    cycle(4'b0000, 1'b0, 1'b0, 4'b0000);
    release dut.bcast_cnt_q;
    cycle(4'b1111, 1'b0, 1'b0, 4'b1000);
    cycle(4'b1111, 1'b0, 1'b0, 4'b0001);
    check("cnt_saturated", bcast_cnt, 16'hFFFF);

    // Reset while a broadcast is on the bus drops it asynchronously.
    cycle(4'b0110, 1'b0, 1'b0, 4'b0010);
    req = 4'b1111;
    #2 RSTn = 1'b0;
    #1;
    check("midrst_valid", cdb_valid, 1'b0);
    check("midrst_cnt", bcast_cnt, 16'h0);
    check("midrst_tag", cdb_tag, 3'd0);
    check("midrst_data", cdb_data, 32'h0);
    check("midrst_src", cdb_src, 2'd0);
    check("midrst_gnt", gnt, 4'b0000);
    @(posedge CLK);
    #1;
    check("midrst_hold_valid", cdb_valid, 1'b0);
    #2 RSTn = 1'b1;
    clear_model();
    cycle(4'b1111, 1'b0, 1'b0, 4'b0001);
    cycle(4'b1111, 1'b0, 1'b0, 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
